// File: rtl/vdf_iteration_controller.sv
// VDF iteration controller: runs the pipelined squarer for T iterations, captures the T-th result,
// flushes the squarer under reset and hands the result over valid/ready. Optional watchdog: VDF_CTRL_TIMEOUT_EN.
module vdf_iteration_controller #(
  parameter int MOD_LEN      = 1024,
  parameter int WORD_LEN     = 16,
  parameter int NUM_ELEMENTS = MOD_LEN/WORD_LEN + 2,
  parameter int SQ_OUT_BITS  = NUM_ELEMENTS*WORD_LEN*2,
  parameter int ITER_W       = 64,
  parameter int FLUSH_CYCLES = 8
`ifdef VDF_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [MOD_LEN-1:0]     cmd_sq_in,
  input  logic [ITER_W-1:0]      cmd_iters,
  input  logic                   abort,
  output logic                   msu_reset,
  output logic                   msu_start,
  output logic [MOD_LEN-1:0]     msu_sq_in,
  input  logic [SQ_OUT_BITS-1:0] msu_sq_out,
  input  logic                   msu_valid,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [SQ_OUT_BITS-1:0] result_data,
  output logic [ITER_W-1:0]      result_iter,
`ifdef VDF_CTRL_TIMEOUT_EN
  output logic                   result_err,
`endif
  output logic                   busy
);

  localparam int FW         = $clog2(FLUSH_CYCLES + 1);
  localparam int SLOT       = 2*WORD_LEN;
  localparam int SEED_WORDS = MOD_LEN/WORD_LEN;

  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                 state;
  logic [ITER_W-1:0]      t_target;
  logic [ITER_W-1:0]      iter_cnt;
  logic [ITER_W-1:0]      iter_next;
  logic [FW-1:0]          flush_cnt;
  logic                   aborted;
  logic [SQ_OUT_BITS-1:0] seed_red;

`ifdef VDF_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;
  logic          timed_out;
`endif

  assign cmd_ready = (state == S_IDLE) && !reset;
  assign busy      = (state != S_IDLE);
  assign msu_reset = reset || (state == S_FLUSH);
  assign iter_next = iter_cnt + ITER_W'(1);

  // Seed in redundant form: each word zero-extended into its 2*WORD_LEN slot, top two slots zero.
  always_comb begin
    seed_red = '0;
    for (int unsigned j = 0; j < SEED_WORDS; j++) begin
      seed_red[j*SLOT +: WORD_LEN] = cmd_sq_in[j*WORD_LEN +: WORD_LEN];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      msu_sq_in    <= '0;
      msu_start    <= 1'b0;
      result_valid <= 1'b0;
      result_data  <= '0;
      result_iter  <= '0;
      t_target     <= '0;
      iter_cnt     <= '0;
      flush_cnt    <= '0;
      aborted      <= 1'b0;
`ifdef VDF_CTRL_TIMEOUT_EN
      wd_cnt       <= '0;
      timed_out    <= 1'b0;
      result_err   <= 1'b0;
`endif
    end else begin
      msu_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            msu_sq_in <= cmd_sq_in;
            t_target  <= cmd_iters;
            iter_cnt  <= '0;
            aborted   <= 1'b0;
`ifdef VDF_CTRL_TIMEOUT_EN
            timed_out <= 1'b0;
`endif
            if (cmd_iters == '0) begin
              result_data  <= seed_red;
              result_iter  <= '0;
              result_valid <= 1'b1;
              state        <= S_DONE;
            end else begin
              msu_start <= 1'b1;
              state     <= S_START;
            end
          end
        end

        S_START: begin
          if (abort) begin
            aborted   <= 1'b1;
            flush_cnt <= '0;
            state     <= S_FLUSH;
          end else begin
`ifdef VDF_CTRL_TIMEOUT_EN
            wd_cnt <= '0;
`endif
            state <= S_RUN;
          end
        end

        // Abort has priority over the final valid (and over the watchdog).
        S_RUN: begin
          if (abort) begin
            aborted   <= 1'b1;
            flush_cnt <= '0;
            state     <= S_FLUSH;
          end else if (msu_valid) begin
            iter_cnt <= iter_next;
`ifdef VDF_CTRL_TIMEOUT_EN
            wd_cnt   <= '0;
`endif
            if (iter_next == t_target) begin
              result_data <= msu_sq_out;
              result_iter <= t_target;
              flush_cnt   <= '0;
              state       <= S_FLUSH;
            end
          end
`ifdef VDF_CTRL_TIMEOUT_EN
          else if (wd_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            timed_out   <= 1'b1;
            result_data <= '0;
            result_iter <= iter_cnt;
            flush_cnt   <= '0;
            state       <= S_FLUSH;
          end else begin
            wd_cnt <= wd_cnt + TW'(1);
          end
`endif
        end

        S_FLUSH: begin
          if (flush_cnt == FW'(FLUSH_CYCLES - 1)) begin
            if (aborted) begin
              state <= S_IDLE;
            end else begin
              result_valid <= 1'b1;
`ifdef VDF_CTRL_TIMEOUT_EN
              result_err   <= timed_out;
`endif
              state        <= S_DONE;
            end
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end

        S_DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
`ifdef VDF_CTRL_TIMEOUT_EN
            result_err   <= 1'b0;
            timed_out    <= 1'b0;
`endif
            state        <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vdf_iteration_controller.sv
// Scoreboard bench for vdf_iteration_controller: stimulus pushes expected results, a negedge monitor pops them.
module tb_vdf_iteration_controller;

  localparam int MOD_LEN = 1024;
  localparam int NUM_EL  = 66;
  localparam int SQ      = 2112;
  localparam int ITER_W  = 64;

  typedef struct {
    logic [SQ-1:0] data;
    logic [63:0]   iter;
    logic          err;
  } exp_t;

  logic               clk;
  logic               reset;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [MOD_LEN-1:0] cmd_sq_in;
  logic [ITER_W-1:0]  cmd_iters;
  logic               abort;
  logic               msu_reset;
  logic               msu_start;
  logic [MOD_LEN-1:0] msu_sq_in;
  logic [SQ-1:0]      msu_sq_out;
  logic               msu_valid;
  logic               result_valid;
  logic               result_ready;
  logic [SQ-1:0]      result_data;
  logic [ITER_W-1:0]  result_iter;
  logic               busy;
`ifdef VDF_CTRL_TIMEOUT_EN
  logic               result_err;
`endif

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  vdf_iteration_controller #(
    .MOD_LEN(1024),
    .WORD_LEN(16),
    .ITER_W(64),
    .FLUSH_CYCLES(8)
`ifdef VDF_CTRL_TIMEOUT_EN
    , .TIMEOUT_CYCLES(50)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_sq_in(cmd_sq_in),
    .cmd_iters(cmd_iters),
    .abort(abort),
    .msu_reset(msu_reset),
    .msu_start(msu_start),
    .msu_sq_in(msu_sq_in),
    .msu_sq_out(msu_sq_out),
    .msu_valid(msu_valid),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result_data(result_data),
    .result_iter(result_iter),
`ifdef VDF_CTRL_TIMEOUT_EN
    .result_err(result_err),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [SQ-1:0] act, input logic [SQ-1:0] exp);
    int bad;
    checks++;
    if (act !== exp) begin
      errors++;
      bad = -1;
      for (int j = 0; j < NUM_EL; j++)
        if (bad < 0 && act[j*32 +: 32] !== exp[j*32 +: 32]) bad = j;
      if (bad < 0) bad = 0;
      $display("FAIL %s slot=%0d actual=%h required=%h", name, bad,
               act[bad*32 +: 32], exp[bad*32 +: 32]);
    end
  endtask

  function automatic logic [SQ-1:0] mkdata(input int p);
    logic [SQ-1:0] d;
    for (int j = 0; j < NUM_EL; j++) d[j*32 +: 32] = (p << 24) | j;
    return d;
  endfunction

  task automatic push_exp(input logic [SQ-1:0] d, input logic [63:0] it, input logic e);
    exp_t x;
    x.data = d;
    x.iter = it;
    x.err  = e;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [MOD_LEN-1:0] s, input logic [63:0] t);
    cmd_valid = 1'b1;
    cmd_sq_in = s;
    cmd_iters = t;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic pulse(input logic [SQ-1:0] d, input logic ab);
    msu_valid  = 1'b1;
    msu_sq_out = d;
    abort      = ab;
    tick();
    msu_valid  = 1'b0;
    abort      = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!result_valid && n < max) begin
      tick();
      n++;
    end
    if (!result_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_result_valid actual=timeout required=valid");
    end
  endtask

  // Monitor: every accepted result is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && result_valid && result_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=valid required=none iter=%0h", result_iter);
      end else begin
        mon_e = sb.pop_front();
        chk_data("result_data", result_data, mon_e.data);
        chk("result_iter", result_iter, mon_e.iter);
`ifdef VDF_CTRL_TIMEOUT_EN
        chk("result_err", result_err, mon_e.err);
`endif
      end
    end
  end

  initial begin
    logic [SQ-1:0] e0;
    int n;
    reset = 1'b1; cmd_valid = 1'b0; cmd_sq_in = '0; cmd_iters = '0;
    abort = 1'b0; msu_valid = 1'b0; msu_sq_out = '0; result_ready = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_msu_reset", msu_reset, 1);
    chk("rst_msu_start", msu_start, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result_iter", result_iter, 0);
    chk_data("rst_result_data", result_data, '0);
    reset = 1'b0;
    #1;
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_msu_reset", msu_reset, 0);

    // T==0: seed words 0x0005 and 0x0001 land in slots 0 and 1
    e0 = '0;
    e0[31:0]  = 32'h0000_0005;
    e0[63:32] = 32'h0000_0001;
    push_exp(e0, 0, 0);
    issue(1024'h1_0005, 0);
    chk("t0_valid_n1", result_valid, 1);
    chk("t0_no_start", msu_start, 0);
    tick();
    chk("t0_valid_drop", result_valid, 0);
    chk("t0_cmd_ready", cmd_ready, 1);

    // T==3 with pulses every 10 cycles
    push_exp(mkdata(3), 3, 0);
    issue(1024'h1234, 3);
    chk("t3_start", msu_start, 1);
    chk("t3_sq_in", msu_sq_in[63:0], 64'h1234);
    tick();
    chk("t3_start_one_cycle", msu_start, 0);
    for (int p = 1; p <= 3; p++) begin
      repeat (9) tick();
      pulse(mkdata(p), 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      chk("t3_flush_reset", msu_reset, 1);
      chk("t3_flush_no_valid", result_valid, 0);
      tick();
    end
    chk("t3_valid_m9", result_valid, 1);
    chk("t3_msu_reset_low", msu_reset, 0);
    tick();

    // Result held with result_ready low; a command offered meanwhile must be ignored
    result_ready = 1'b0;
    push_exp(mkdata(9), 1, 0);
    issue(1024'hABCD, 1);
    tick();
    pulse(mkdata(9), 1'b0);
    repeat (8) tick();
    chk("hold_valid", result_valid, 1);
    for (int i = 0; i < 20; i++) begin
      chk_data("hold_data", result_data, mkdata(9));
      chk("hold_cmd_ready", cmd_ready, 0);
      cmd_valid = (i == 5);
      cmd_sq_in = 1024'h7;
      cmd_iters = 0;
      tick();
    end
    cmd_valid = 1'b0;
    chk("hold_iter", result_iter, 1);
    result_ready = 1'b1;
    tick();
    chk("hs_valid_drop", result_valid, 0);
    chk("hs_cmd_ready", cmd_ready, 1);
    e0 = '0;
    e0[31:0] = 32'h0000_0077;
    push_exp(e0, 0, 0);
    issue(1024'h77, 0);
    chk("next_cmd_valid", result_valid, 1);
    tick();

    // Abort coinciding with the final valid of a T=2 run
    issue(1024'h55, 2);
    tick();
    pulse(mkdata(1), 1'b0);
    repeat (3) tick();
    pulse(mkdata(2), 1'b1);
    chk("abort_flush", msu_reset, 1);
    for (int i = 0; i < 8; i++) begin
      chk("abort_no_valid", result_valid, 0);
      tick();
    end
    chk("abort_idle", busy, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_final_no_valid", result_valid, 0);

    // Reset in RUN after 1 of 5 iterations, then a fresh T=1 run
    issue(1024'h66, 5);
    tick();
    pulse(mkdata(1), 1'b0);
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("mrst_busy", busy, 0);
    chk("mrst_cmd_ready", cmd_ready, 0);
    chk("mrst_msu_reset", msu_reset, 1);
    chk("mrst_result_valid", result_valid, 0);
    chk("mrst_result_iter", result_iter, 0);
    chk_data("mrst_result_data", result_data, '0);
    reset = 1'b0;
    #1;
    chk("mrst_cmd_ready_after", cmd_ready, 1);
    push_exp(mkdata(4), 1, 0);
    issue(1024'h99, 1);
    chk("t1_start", msu_start, 1);
    tick();
    pulse(mkdata(4), 1'b0);
    wait_valid(20, n);
    chk("t1_latency", n, 8);
    tick();

`ifdef VDF_CTRL_TIMEOUT_EN
    // Squarer goes silent after 2 of 4 valids
    push_exp('0, 2, 1);
    issue(1024'h33, 4);
    tick();
    pulse(mkdata(5), 1'b0);
    repeat (4) tick();
    pulse(mkdata(6), 1'b0);
    wait_valid(200, n);
    tick();
`endif

    repeat (4) tick();
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
